// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage and the ALU control decoder:
// opcode encoding, FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// 32 iterations. done/product are combinational on the final iteration.
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic [4:0]      cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] addend;

    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    // Counter value 31 means the current edge completes iteration 32.
    assign done    = busy && !flush && (cnt == 5'd31);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_execute.sv
// ALU execute stage: single-cycle logic/arith/shift ops and a multiply that is
// iterative by default or single-cycle when ALU_FAST_MUL_EN is defined.
module alu_execute
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      ALUCtrl_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] data_o,
    output logic            zero_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] res;
    logic            accept;
    logic            res_load;
    logic [XLEN-1:0] res_val;

    assign shamt  = data2_i[4:0];
    assign accept = valid_i && ready_o && !flush_i;

    always_comb begin
        res = '0;
        case (alu_op_e'(ALUCtrl_i))
            ALU_AND:           res = data1_i & data2_i;
            ALU_XOR:           res = data1_i ^ data2_i;
            ALU_SLL:           res = data1_i << shamt;
            ALU_ADD, ALU_ADDI: res = data1_i + data2_i;
            ALU_SUB:           res = data1_i - data2_i;
            ALU_SRAI:          res = $signed(data1_i) >>> shamt;
`ifdef ALU_FAST_MUL_EN
            ALU_MUL:           res = data1_i * data2_i;
`endif
            default:           res = '0;
        endcase
    end

`ifdef ALU_FAST_MUL_EN
    assign ready_o  = 1'b1;
    assign res_load = accept;
    assign res_val  = res;
`else
    alu_state_e      state_q, state_d;
    logic            is_mul;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign is_mul  = (ALUCtrl_i == ALU_MUL);
    assign ready_o = (state_q == ST_IDLE);

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (accept && is_mul),
        .flush   (flush_i && state_q == ST_MUL),
        .a       (data1_i),
        .b       (data2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
            ST_MUL:  if (flush_i || mul_done || !mul_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign res_load = (accept && !is_mul) || mul_done;
    assign res_val  = mul_done ? mul_product : res;
`endif

    // data_o/zero_o only move on a result; they hold across flushes and idles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b1;
        end else begin
            valid_o <= res_load;
            if (res_load) begin
                data_o <= res_val;
                zero_o <= (res_val == '0);
            end
        end
    end

endmodule

// File: doc/alu_execute.md
ALU_EXECUTE -- requirements
Module: alu_execute

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port valid_i, input, 1: operation request present.
REQ-005 SHALL have port ALUCtrl_i, input, 3: operation code; 000 and, 001 xor, 010 sll, 011 add, 100 sub, 101 mul, 110 addi, 111 srai.
REQ-006 SHALL have port data1_i, input, XLEN: operand A (rs1).
REQ-007 SHALL have port data2_i, input, XLEN: operand B (rs2 or sign-extended immediate).
REQ-008 SHALL have port flush_i, input, 1: abort the in-flight operation.
REQ-009 SHALL have port ready_o, output, 1: a request is accepted this cycle.
REQ-010 SHALL have port valid_o, output, 1: one-cycle pulse; data_o/zero_o are valid.
REQ-011 SHALL have port data_o, output, XLEN: registered result.
REQ-012 SHALL have port zero_o, output, 1: high when the registered result equals 0.

Function
REQ-013 SHALL accept a request on a rising edge where valid_i=1, ready_o=1 and flush_i=0; valid_i while ready_o=0 is ignored, and upstream holds it.
REQ-014 SHALL use states IDLE (ready_o=1) and MUL (ready_o=0).
REQ-015 SHALL, for non-mul codes accepted in IDLE, register the result and pulse valid_o in the next cycle, stay in IDLE, and sustain one op per cycle.
REQ-016 SHALL compute: and/xor bitwise; add and addi as A+B modulo 2^XLEN; sub as A-B modulo 2^XLEN; sll as A << B[4:0]; srai as arithmetic A >>> B[4:0].
REQ-017 SHALL, on accepting mul in IDLE, latch A and B, clear the partial product and a 5-bit counter, and enter MUL.
REQ-018 SHALL, in MUL, do one shift-add iteration per cycle over one multiplier bit, LSB first, for 32 iterations.
REQ-019 SHALL, on the edge finishing iteration 32, write the low XLEN bits of A*B to data_o, pulse valid_o, and return to IDLE.
REQ-020 SHALL give mul a latency of 32 cycles from acceptance to valid_o, with ready_o low for exactly those 32 cycles.
REQ-021 SHALL, on flush_i=1 in MUL, return to IDLE at the next edge with no valid_o and data_o unchanged.
REQ-022 SHALL, on flush_i=1 in IDLE, accept nothing and give no valid_o next cycle; flush_i wins over a simultaneous valid_i.
REQ-023 SHALL hold data_o and zero_o when valid_o=0; zero_o is updated together with data_o.
REQ-024 SHALL keep an unrecognised state unreachable, with a default branch returning to IDLE.

Reset
REQ-025 SHALL, on rst_i low, immediately force state IDLE, ready_o=1, valid_o=0, data_o=0, zero_o=1, counter and partial product 0, including during a mul.
REQ-026 SHALL accept a request on the first rising edge after rst_i deasserts.

Configuration
REQ-027 SHALL use macro ALU_FAST_MUL_EN: when defined, mul is a single-cycle combinational product, handled exactly like the REQ-015 ops, and the MUL state and counter are not built.
REQ-028 SHALL, without ALU_FAST_MUL_EN, implement the iterative multiply of REQ-017..REQ-021.

Structure
REQ-029 SHALL place the ALUCtrl opcode constants, the state encoding and XLEN default in shared package alu_pkg, used by alu_execute and the ALU control decoder.
REQ-030 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, flush, busy, done, product), instantiated only without ALU_FAST_MUL_EN.

Verification
REQ-031 SHALL test: add A=5, B=7 -> next cycle valid_o=1, data_o=12, zero_o=0; sub A=3, B=5 -> data_o=0xFFFFFFFE.
REQ-032 SHALL test: srai A=0x80000000, B=4 -> 0xF8000000; sll A=1, B=0x21 -> 0x00000002 (shift amount B[4:0]=1).
REQ-033 SHALL test: mul A=0xFFFFFFFF, B=3 -> ready_o low 32 cycles, then a single valid_o with data_o=0xFFFFFFFD; with ALU_FAST_MUL_EN, same value one cycle after acceptance.
REQ-034 SHALL test: back-to-back xor, and, add on consecutive cycles -> three consecutive valid_o pulses with correct results; sub A=9, B=9 -> zero_o=1.
REQ-035 SHALL test: flush_i in mul iteration 10 -> no valid_o, ready_o=1 next cycle, data_o keeps its prior value; valid_i+flush_i together in IDLE -> nothing accepted.
REQ-036 SHALL test: rst_i low mid-mul -> outputs take reset values immediately; after release, add 1+1 -> 2 with one-cycle latency.
